// File: rtl/normalize.sv
// Pipelined leading-zero normalizer: shifts the input word left until its MSB
// is set and reports the shift count. One stage per shift-count bit, most
// significant bit first, so a word emerges NORM_W clock edges after it is sampled.
module normalize #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     valid_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(WIDTH)-1:0] norm_o,
    output logic                     valid_o
);

    localparam int unsigned NORM_W = $clog2(WIDTH);

    // The stage shift amounts only add up to WIDTH-1 for a power-of-two width.
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("normalize: WIDTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0]  data_q [NORM_W];
    logic [WIDTH-1:0]  data_d [NORM_W];
    logic [NORM_W-1:0] norm_q [NORM_W];
    logic [NORM_W-1:0] norm_d [NORM_W];
    logic [NORM_W-1:0] valid_q;
    logic [NORM_W-1:0] valid_d;

    // Mask selecting the top 2^k bits of a word.
    function automatic logic [WIDTH-1:0] top_mask(input int unsigned k);
        return ~({WIDTH{1'b1}} >> (1 << k));
    endfunction

    // Next state of every stage: stage s resolves norm bit NORM_W-1-s.
    always_comb begin
        logic [WIDTH-1:0]  word_in;
        logic [NORM_W-1:0] norm_in;
        int unsigned       k;

        word_in = data_i;
        norm_in = '0;
        k       = 0;
        valid_d = '0;
        for (int unsigned s = 0; s < NORM_W; s++) begin
            data_d[s] = '0;
            norm_d[s] = '0;
        end

        valid_d[0] = valid_i;
        for (int unsigned s = 1; s < NORM_W; s++) begin
            valid_d[s] = valid_q[s-1];
        end

        for (int unsigned s = 0; s < NORM_W; s++) begin
            k = NORM_W - 1 - s;
            if ((word_in & top_mask(k)) == '0) begin
                data_d[s] = word_in << (1 << k);
                norm_d[s] = norm_in | (NORM_W'(1) << k);
            end else begin
                data_d[s] = word_in;
                norm_d[s] = norm_in;
            end
            // Next stage consumes this stage's registered result.
            if (s + 1 < NORM_W) begin
                word_in = data_q[s];
                norm_in = norm_q[s];
            end
        end
    end

    // Pipeline registers; data and norm load every cycle, valid tracks the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned s = 0; s < NORM_W; s++) begin
                data_q[s] <= '0;
                norm_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned s = 0; s < NORM_W; s++) begin
                data_q[s] <= data_d[s];
                norm_q[s] <= norm_d[s];
            end
        end
    end

    assign data_o  = data_q[NORM_W-1];
    assign norm_o  = norm_q[NORM_W-1];
    assign valid_o = valid_q[NORM_W-1];

endmodule

// File: tb/tb_normalize.sv
// Self-checking bench for normalize (WIDTH=16): directed vector table, sweep,
// random stream, gap-preserving stream and mid-stream reset.
module tb_normalize;

    localparam int W  = 16;
    localparam int NW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data_i = '0;
    logic          valid_i = 1'b0;
    logic [W-1:0]  data_o;
    logic [NW-1:0] norm_o;
    logic          valid_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic [W-1:0]  ed;
        logic [NW-1:0] en;
    } vec_t;

    vec_t vecs [12];

    logic         s_v [$];
    logic [W-1:0] s_d [$];

    normalize #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .data_i  (data_i),
        .valid_i (valid_i),
        .data_o  (data_o),
        .norm_o  (norm_o),
        .valid_o (valid_o)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: shift until MSB set, count capped at W-1.
    function automatic void ref_norm(input logic [W-1:0] d, output logic [W-1:0] od,
                                     output logic [NW-1:0] on);
        int n;
        od = d;
        n  = 0;
        while (od[W-1] == 1'b0 && n < W - 1) begin
            od = od << 1;
            n++;
        end
        on = NW'(n);
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single word into an idle pipeline: latency, result and one-cycle valid pulse.
    task automatic one_word(input logic [W-1:0] d, input logic [W-1:0] ed,
                            input logic [NW-1:0] en, input string name);
        int lat;
        bit seen;
        data_i  = d;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
        lat  = 1;
        seen = 0;
        while (!seen && lat <= 12) begin
            if (valid_o) seen = 1;
            else begin
                tick();
                lat++;
            end
        end
        if (!seen) begin
            check({name, " timeout"}, 32'(valid_o), 32'd1);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(NW));
            check({name, " data"}, 32'(data_o), 32'(ed));
            check({name, " norm"}, 32'(norm_o), 32'(en));
            tick();
            check({name, " pulse"}, 32'(valid_o), 32'd0);
        end
    endtask

    // Drive s_v/s_d one entry per cycle from an idle pipeline; every output cycle
    // must equal the input pattern delayed by NW edges.
    task automatic run_stream(input string name);
        int n;
        logic [W-1:0]  ed;
        logic [NW-1:0] en;
        n = s_v.size();
        for (int t = 0; t < n + NW - 1; t++) begin
            if (t < n) begin
                valid_i = s_v[t];
                data_i  = s_d[t];
            end else begin
                valid_i = 1'b0;
                data_i  = '0;
            end
            tick();
            if (t >= NW - 1) begin
                int i;
                i = t - (NW - 1);
                check($sformatf("%s valid[%0d]", name, i), 32'(valid_o), 32'(s_v[i]));
                if (s_v[i]) begin
                    ref_norm(s_d[i], ed, en);
                    check($sformatf("%s data[%0d]", name, i), 32'(data_o), 32'(ed));
                    check($sformatf("%s norm[%0d]", name, i), 32'(norm_o), 32'(en));
                end
            end else begin
                check($sformatf("%s early valid t=%0d", name, t), 32'(valid_o), 32'd0);
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        logic [W-1:0]  ed;
        logic [NW-1:0] en;

        vecs[0]  = '{16'h0000, 16'h0000, 4'd15};
        vecs[1]  = '{16'h0001, 16'h8000, 4'd15};
        vecs[2]  = '{16'h0003, 16'hC000, 4'd14};
        vecs[3]  = '{16'h0040, 16'h8000, 4'd9};
        vecs[4]  = '{16'h8000, 16'h8000, 4'd0};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 4'd0};
        vecs[6]  = '{16'h00F0, 16'hF000, 4'd8};
        vecs[7]  = '{16'h1234, 16'h91A0, 4'd3};
        vecs[8]  = '{16'h4000, 16'h8000, 4'd1};
        vecs[9]  = '{16'h7FFF, 16'hFFFE, 4'd1};
        vecs[10] = '{16'h0100, 16'h8000, 4'd7};
        vecs[11] = '{16'h0005, 16'hA000, 4'd13};

        // Reset held 10 cycles with valid_i high: outputs stay cleared.
        reset   = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'h8000;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("reset valid c%0d", c), 32'(valid_o), 32'd0);
            check($sformatf("reset data c%0d", c), 32'(data_o), 32'd0);
            check($sformatf("reset norm c%0d", c), 32'(norm_o), 32'd0);
        end

        // First word after reset release appears NW edges later.
        reset  = 1'b0;
        data_i = 16'h0001;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
        check("post-reset valid e1", 32'(valid_o), 32'd0);
        tick();
        check("post-reset valid e2", 32'(valid_o), 32'd0);
        tick();
        check("post-reset valid e3", 32'(valid_o), 32'd0);
        tick();
        check("post-reset valid e4", 32'(valid_o), 32'd1);
        check("post-reset data", 32'(data_o), 32'h8000);
        check("post-reset norm", 32'(norm_o), 32'd15);
        tick();
        check("post-reset pulse", 32'(valid_o), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            one_word(vecs[i].d, vecs[i].ed, vecs[i].en, $sformatf("vec%0d", i));
        end

        // Sweep 0..99, one word at a time.
        for (int v = 0; v < 100; v++) begin
            ref_norm(W'(v), ed, en);
            one_word(W'(v), ed, en, $sformatf("sweep%0d", v));
        end

        // Random back-to-back words.
        s_v.delete();
        s_d.delete();
        for (int i = 0; i < 120; i++) begin
            s_v.push_back(1'b1);
            s_d.push_back(W'($urandom) >> $urandom_range(0, 15));
        end
        run_stream("random");

        // 8 words, 1-cycle gap, 3 words.
        s_v.delete();
        s_d.delete();
        for (int i = 0; i < 12; i++) begin
            s_v.push_back(i != 8);
            s_d.push_back((i == 8) ? 16'hDEAD : (16'h0009 << i));
        end
        run_stream("gap");

        // Reset with three words in flight: none may emerge.
        valid_i = 1'b1;
        data_i  = 16'h0011;
        tick();
        data_i  = 16'h0022;
        tick();
        data_i  = 16'h0033;
        tick();
        reset   = 1'b1;
        data_i  = 16'h0044;
        tick();
        reset   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("flush valid c%0d", c), 32'(valid_o), 32'd0);
            tick();
        end
        one_word(16'h00F0, 16'hF000, 4'd8, "after-flush");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
